zero_indices_stream: RTL and testbench

- Parametrised next-generation zero/one-index enumerator.
- Loads a W-bit vector on a start pulse and streams the index of every matching bit (zeros or ones, selectable per job) in ascending order.
- Output is valid/ready with a last flag; throughput is one index per cycle with no bubbles.
- Ends every job with a one-cycle completion summary (count, abort flag); supports abort mid-job. Sits behind any requester that needs free-slot or set-bit enumeration.

---
 rtl/zero_indices_stream.sv | 148 ++++++++++++++
 tb/tb_zero_indices_stream.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/zero_indices_stream.sv
// Streams the ascending indices of every zero (or one) bit of a loaded vector,
// one per cycle over valid/ready, then emits a one-cycle completion summary.
module zero_indices_stream #(
  parameter  int W     = 128,
  parameter  int V     = 16,
  localparam int IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_vector,
  input  logic             in_polarity,
  input  logic             in_start,
  input  logic             in_abort,
  output logic             in_busy_r,
  output logic             resp_valid_r,
  input  logic             resp_ready,
  output logic [IDX_W-1:0] resp_index_r,
  output logic             resp_last_r,
  output logic             done_valid_r,
  output logic [IDX_W:0]   done_count_r,
  output logic             done_aborted_r
);

  localparam int NSEG  = W / V;
  localparam int OFF_W = $clog2(V);
  localparam int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           state_r, state_nxt;
  logic [W-1:0]     p_r, load_vec, p_after, scan;
  logic [IDX_W:0]   count_r, count_inc;
  logic             hs, start_acc, abort_acc;
  logic             finish, finish_aborted;
  logic [NSEG-1:0]  seg_any;
  logic [OFF_W-1:0] seg_off [NSEG];
  logic [SEG_W-1:0] sel_seg;
  logic [OFF_W-1:0] sel_off;
  logic [IDX_W-1:0] ff_idx;
  logic             ff_any, ff_single;

  // Handshake/valid contract: an index transfers on any rising edge where
  // resp_valid_r & resp_ready; while valid is high and ready is low, the
  // index, last flag and valid are held unchanged.
  assign hs        = resp_valid_r & resp_ready;
  assign start_acc = (state_r == S_IDLE) & in_start;
  assign abort_acc = (state_r == S_BUSY) & in_abort;
  assign in_busy_r = (state_r == S_BUSY);

  assign load_vec  = in_polarity ? in_vector : ~in_vector;
  assign p_after   = hs ? (p_r & ~(W'(1) << resp_index_r)) : p_r;
  // A freshly loaded vector and the post-handshake remainder share one finder.
  assign scan      = start_acc ? load_vec : p_after;
  assign count_inc = count_r + {{IDX_W{1'b0}}, hs};

  // Level 1: lowest set bit inside each V-bit segment.
  always_comb begin
    for (int s = 0; s < NSEG; s++) begin
      seg_any[s] = |scan[s*V +: V];
      seg_off[s] = '0;
      for (int b = V - 1; b >= 0; b--) begin
        if (scan[s*V + b]) seg_off[s] = OFF_W'(b);
      end
    end
  end

  // Level 2: lowest non-empty segment.
  always_comb begin
    sel_seg = '0;
    sel_off = '0;
    for (int s = NSEG - 1; s >= 0; s--) begin
      if (seg_any[s]) begin
        sel_seg = SEG_W'(s);
        sel_off = seg_off[s];
      end
    end
  end

  assign ff_idx    = IDX_W'(int'(sel_seg) * V) + IDX_W'(sel_off);
  assign ff_any    = |seg_any;
  assign ff_single = ff_any && ((scan & (scan - W'(1))) == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE:  if (start_acc && ff_any) state_nxt = S_BUSY;
      S_BUSY:  if (finish)              state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A last-index handshake coinciding with abort is an ordinary completion.
  always_comb begin
    finish         = 1'b0;
    finish_aborted = 1'b0;
    if (state_r == S_BUSY) begin
      finish         = (hs & resp_last_r) | abort_acc;
      finish_aborted = abort_acc & ~(hs & resp_last_r);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_r            <= '0;
      count_r        <= '0;
      resp_valid_r   <= 1'b0;
      resp_index_r   <= '0;
      resp_last_r    <= 1'b0;
      done_valid_r   <= 1'b0;
      done_count_r   <= '0;
      done_aborted_r <= 1'b0;
    end else begin
      done_valid_r <= 1'b0;
      if (start_acc) begin
        p_r          <= load_vec;
        count_r      <= '0;
        resp_valid_r <= ff_any;
        resp_index_r <= ff_idx;
        resp_last_r  <= ff_single;
        if (!ff_any) begin
          done_valid_r   <= 1'b1;
          done_count_r   <= '0;
          done_aborted_r <= 1'b0;
        end
      end else if (finish) begin
        p_r            <= '0;
        count_r        <= count_inc;
        resp_valid_r   <= 1'b0;
        resp_index_r   <= '0;
        resp_last_r    <= 1'b0;
        done_valid_r   <= 1'b1;
        done_count_r   <= count_inc;
        done_aborted_r <= finish_aborted;
      end else if (hs) begin
        p_r          <= p_after;
        count_r      <= count_inc;
        resp_index_r <= ff_idx;
        resp_last_r  <= ff_single;
      end
    end
  end

endmodule

// File: tb/tb_zero_indices_stream.sv
// Bench for zero_indices_stream: directed scenarios plus randomized jobs
// checked cycle by cycle against a per-bit reference queue.
module tb_zero_indices_stream;

  localparam int W     = 128;
  localparam int V     = 16;
  localparam int IDX_W = $clog2(W);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     in_vector;
  logic             in_polarity;
  logic             in_start;
  logic             in_abort;
  logic             in_busy_r;
  logic             resp_valid_r;
  logic             resp_ready;
  logic [IDX_W-1:0] resp_index_r;
  logic             resp_last_r;
  logic             done_valid_r;
  logic [IDX_W:0]   done_count_r;
  logic             done_aborted_r;

  int tests  = 0;
  int failed = 0;
  logic [IDX_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  zero_indices_stream #(.W(W), .V(V)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_vector      (in_vector),
    .in_polarity    (in_polarity),
    .in_start       (in_start),
    .in_abort       (in_abort),
    .in_busy_r      (in_busy_r),
    .resp_valid_r   (resp_valid_r),
    .resp_ready     (resp_ready),
    .resp_index_r   (resp_index_r),
    .resp_last_r    (resp_last_r),
    .done_valid_r   (done_valid_r),
    .done_count_r   (done_count_r),
    .done_aborted_r (done_aborted_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"},       32'(in_busy_r),      0);
    check({pfx, "_valid"},      32'(resp_valid_r),   0);
    check({pfx, "_index"},      32'(resp_index_r),   0);
    check({pfx, "_last"},       32'(resp_last_r),    0);
    check({pfx, "_done"},       32'(done_valid_r),   0);
    check({pfx, "_done_count"}, 32'(done_count_r),   0);
    check({pfx, "_aborted"},    32'(done_aborted_r), 0);
  endtask

  // Reference: every bit position whose value equals the polarity, ascending.
  task automatic build_exp(input logic [W-1:0] vec, input logic pol);
    exp_q.delete();
    for (int i = 0; i < W; i++)
      if (vec[i] == pol) exp_q.push_back(IDX_W'(i));
  endtask

  // ready_mode: 0 random, 1 always high, 2 low for three cycles then high,
  // 3 high only in the first response cycle. abort_cyc 0 means no abort.
  // Starts at a falling edge, returns at the falling edge showing done.
  task automatic run_job(input string name, input logic [W-1:0] vec, input logic pol,
                         input int ready_mode, input int abort_cyc, input bit noise);
    int   handed;
    int   cyc;
    bit   expect_done;
    bit   exp_ab;
    bit   finished;
    logic rdy;
    logic ab;
    handed = 0; cyc = 0; expect_done = 0; exp_ab = 0; finished = 0;
    build_exp(vec, pol);
    in_vector   = vec;
    in_polarity = pol;
    in_start    = 1'b1;
    in_abort    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    resp_ready  = 1'($urandom_range(0, 1));
    if (exp_q.size() == 0) expect_done = 1;
    @(negedge clk);
    in_start = 1'b0;
    in_abort = 1'b0;
    while (!finished) begin
      cyc++;
      if (cyc > W + 64) begin
        check({name, "_timeout"}, 32'(finished), 1);
        break;
      end
      if (expect_done) begin
        check({name, "_done_valid"}, 32'(done_valid_r),   1);
        check({name, "_done_rvalid"}, 32'(resp_valid_r),  0);
        check({name, "_done_busy"},  32'(in_busy_r),      0);
        check({name, "_done_count"}, 32'(done_count_r),   32'(handed));
        check({name, "_done_abort"}, 32'(done_aborted_r), 32'(exp_ab));
        finished = 1;
      end else begin
        check({name, "_valid"},      32'(resp_valid_r), 1);
        check({name, "_busy"},       32'(in_busy_r),    1);
        check({name, "_early_done"}, 32'(done_valid_r), 0);
        check({name, "_index"},      32'(resp_index_r), 32'(exp_q[0]));
        check({name, "_last"},       32'(resp_last_r),  32'(exp_q.size() == 1));
        case (ready_mode)
          0:       rdy = ($urandom_range(0, 3) != 0);
          1:       rdy = 1'b1;
          2:       rdy = (cyc > 3);
          default: rdy = (cyc == 1);
        endcase
        ab = (cyc == abort_cyc);
        resp_ready = rdy;
        in_abort   = ab;
        if (noise && $urandom_range(0, 2) == 0) begin
          in_start    = 1'b1;
          in_polarity = 1'($urandom_range(0, 1));
          for (int i = 0; i < W; i++) in_vector[i] = 1'($urandom_range(0, 1));
        end else begin
          in_start = 1'b0;
        end
        if (rdy) begin
          void'(exp_q.pop_front());
          handed++;
        end
        if (rdy && exp_q.size() == 0) begin
          expect_done = 1;
          exp_ab      = 0;
        end else if (ab) begin
          expect_done = 1;
          exp_ab      = 1;
        end
        @(negedge clk);
      end
    end
    in_start   = 1'b0;
    in_abort   = 1'b0;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] vec;
    int           dens;
    int           wait_cyc;

    rst_n       = 1'b0;
    in_vector   = '0;
    in_polarity = 1'b0;
    in_start    = 1'b0;
    in_abort    = 1'b0;
    resp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    vec = '1; vec[3] = 1'b0; vec[17] = 1'b0; vec[127] = 1'b0;
    run_job("sparse", vec, 1'b0, 1, 0, 0);

    run_job("empty_ones", '1, 1'b0, 1, 0, 0);
    run_job("empty_zeros", '0, 1'b1, 1, 0, 0);

    vec = '1; vec[0] = 1'b0; vec[1] = 1'b0;
    run_job("backpressure", vec, 1'b0, 2, 0, 0);

    vec = '1; vec[5] = 1'b0; vec[20] = 1'b0; vec[40] = 1'b0; vec[60] = 1'b0; vec[100] = 1'b0;
    run_job("abort", vec, 1'b0, 3, 2, 0);

    for (int i = 0; i < W; i++) vec[i] = 1'($urandom_range(0, 1));
    run_job("start_busy", vec, 1'b0, 0, 0, 1);

    run_job("full", '0, 1'b0, 1, 0, 0);

    // Idle abort must not disturb the held summary.
    in_abort = 1'b1;
    @(negedge clk);
    in_abort = 1'b0;
    check("idle_abort_busy",    32'(in_busy_r),      0);
    check("idle_abort_done",    32'(done_valid_r),   0);
    check("idle_abort_rvalid",  32'(resp_valid_r),   0);
    check("held_done_count",    32'(done_count_r),   W);
    check("held_done_aborted",  32'(done_aborted_r), 0);

    // Reset in the middle of a full-density job.
    in_vector   = '0;
    in_polarity = 1'b0;
    in_start    = 1'b1;
    resp_ready  = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    wait_cyc = 0;
    while (resp_index_r != IDX_W'(60) && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("reach_60", 32'(resp_index_r), 60);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midjob_reset");
    rst_n      = 1'b1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("post_reset_done", 32'(done_valid_r), 0);
    check("post_reset_busy", 32'(in_busy_r),    0);

    vec = '1; vec[64] = 1'b0; vec[65] = 1'b0;
    run_job("after_reset", vec, 1'b0, 1, 0, 0);

    repeat (40) begin
      dens = $urandom_range(0, 100);
      for (int i = 0; i < W; i++) vec[i] = ($urandom_range(0, 99) < dens);
      run_job("rand", vec, 1'($urandom_range(0, 1)), $urandom_range(0, 1),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0,
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
